// File: rtl/mem_stage_pkg.sv
// Shared codes for the MEM pipeline stage: MemToReg selects, access sizes and FSM states.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10
    } mtr_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port. The stage is the master; the memory model or controller is the slave.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_align.sv
// Sub-word lane steering for the MEM stage: byte enables, store replication, load extraction
// and sign/zero extension. Only instantiated when MEM_SUBWORD_EN is defined.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane and format it according to the access size.
    always_comb begin
        w_byte     = i_rdata[{i_addr, 3'b000} +: 8];
        w_half     = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_be       = BE_ALL;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be       = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
                o_misalign = i_addr[0];
            end
            default: begin
                o_misalign = (i_addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers plus a req/ack data-memory FSM with timeout.
// Optional feature macro: MEM_SUBWORD_EN (byte/half accesses through mem_align).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_Valid,
    input  logic [31:0] EX_ALUOut,
    input  logic [31:0] EX_MemWriteData,
    input  logic [4:0]  EX_WriteRegister,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [1:0]  EX_MemToReg,
    input  logic [31:0] EX_PCPlus4,
    input  logic [1:0]  EX_MemSize,
    input  logic        EX_MemUnsigned,
    mem_stage_if.master dmem,
    output logic        MEM_Stall,
    output logic        MEM_RegWrite,
    output logic [4:0]  MEM_WriteRegister,
    output logic [31:0] MEM_RegWriteData,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_WriteRegister,
    output logic [31:0] WB_RegWriteData,
    output logic        dmem_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic        r_em_valid, r_em_rw, r_em_mrd, r_em_mwr, r_em_uns;
    logic [31:0] r_em_alu, r_em_wdata, r_em_pc4;
    logic [4:0]  r_em_rd;
    logic [1:0]  r_em_mtr, r_em_size;

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_abort, w_abort_nxt;
    logic          r_req, w_req_nxt, r_we, w_we_nxt;
    logic [31:0]   r_addr, w_addr_nxt, r_wdata, w_wdata_nxt;
    logic [3:0]    r_be, w_be_nxt;
    logic          r_err;
    logic          r_wb_rw;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_wb_data;

    logic        w_mem_op, w_busy, w_ack_ok, w_timeout, w_stall, w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_lane_wdata, w_load_data, w_fwd_data;

`ifdef MEM_SUBWORD_EN
    mem_align u_align (
        .i_size     (r_em_size),
        .i_unsigned (r_em_uns),
        .i_addr     (r_em_alu[1:0]),
        .i_wdata    (r_em_wdata),
        .i_rdata    (dmem.dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_lane_wdata),
        .o_rdata    (w_load_data),
        .o_misalign (w_misalign)
    );
`else
    logic w_unused_ok;
    assign w_be         = BE_ALL;
    assign w_lane_wdata = r_em_wdata;
    assign w_load_data  = dmem.dmem_rdata;
    assign w_misalign   = 1'b0;
    assign w_unused_ok  = ^{r_em_size, r_em_uns};
`endif

    // An abandoned access (timeout or misaligned) completes without ack; acks are only honoured for a live request.
    assign w_mem_op  = r_em_valid & (r_em_mrd | r_em_mwr);
    assign w_busy    = (r_state == S_BUSY);
    assign w_ack_ok  = w_busy & dmem.dmem_ack & ~r_abort;
    assign w_timeout = w_busy & ~w_ack_ok & (r_abort | (r_cnt == CNT_LAST));
    assign w_stall   = w_mem_op & ~(w_ack_ok | w_timeout);

    // EX/MEM pipeline register, frozen while the stage stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_em_valid <= 1'b0;  r_em_rw   <= 1'b0;  r_em_mrd  <= 1'b0;
            r_em_mwr   <= 1'b0;  r_em_uns  <= 1'b0;  r_em_alu  <= 32'h0;
            r_em_wdata <= 32'h0; r_em_pc4  <= 32'h0; r_em_rd   <= 5'd0;
            r_em_mtr   <= 2'b00; r_em_size <= 2'b00;
        end else if (!w_stall) begin
            r_em_valid <= EX_Valid;        r_em_rw   <= EX_RegWrite;
            r_em_mrd   <= EX_MemRead;      r_em_mwr  <= EX_MemWrite;
            r_em_uns   <= EX_MemUnsigned;  r_em_alu  <= EX_ALUOut;
            r_em_wdata <= EX_MemWriteData; r_em_pc4  <= EX_PCPlus4;
            r_em_rd    <= EX_WriteRegister; r_em_mtr <= EX_MemToReg;
            r_em_size  <= EX_MemSize;
        end
    end

    // Access FSM next state and next values of the registered request outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = r_abort;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_be_nxt    = r_be;
        w_wdata_nxt = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = {CW{1'b0}};
                    w_abort_nxt = w_misalign;
                    w_req_nxt   = ~w_misalign;
                    w_we_nxt    = r_em_mwr;
                    w_addr_nxt  = {r_em_alu[31:2], 2'b00};
                    w_be_nxt    = w_be;
                    w_wdata_nxt = w_lane_wdata;
                end else begin
                    w_req_nxt = 1'b0;
                end
            end
            S_BUSY: begin
                if (w_ack_ok || w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = 1'b0;
                    w_abort_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // Access FSM state, counter, request registers and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE; r_cnt   <= {CW{1'b0}}; r_abort <= 1'b0;
            r_req   <= 1'b0;   r_we    <= 1'b0;       r_addr  <= 32'h0;
            r_be    <= 4'h0;   r_wdata <= 32'h0;      r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt; r_cnt   <= w_cnt_nxt;   r_abort <= w_abort_nxt;
            r_req   <= w_req_nxt;   r_we    <= w_we_nxt;    r_addr  <= w_addr_nxt;
            r_be    <= w_be_nxt;    r_wdata <= w_wdata_nxt; r_err   <= r_err | w_timeout;
        end
    end

    // Forwarding value; load data is only meaningful in the ack cycle.
    always_comb begin
        case (r_em_mtr)
            MTR_ALU: w_fwd_data = r_em_alu;
            MTR_MEM: w_fwd_data = w_load_data;
            MTR_PC4: w_fwd_data = r_em_pc4;
            default: w_fwd_data = r_em_alu;
        endcase
    end

    // MEM/WB register: a stall cycle becomes a bubble, an abandoned load writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_rw   <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'h0;
        end else if (w_stall) begin
            r_wb_rw <= 1'b0;
        end else begin
            r_wb_rw   <= r_em_valid & r_em_rw & ~(w_timeout & r_em_mrd);
            r_wb_rd   <= r_em_rd;
            r_wb_data <= (w_timeout & r_em_mrd) ? 32'h0 : w_fwd_data;
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
    assign MEM_Stall         = w_stall;
    assign MEM_RegWrite      = r_em_valid & r_em_rw;
    assign MEM_WriteRegister = r_em_rd;
    assign MEM_RegWriteData  = w_fwd_data;
    assign WB_RegWrite       = r_wb_rw;
    assign WB_WriteRegister  = r_wb_rd;
    assign WB_RegWriteData   = r_wb_data;
    assign dmem_err          = r_err;

endmodule
